laser_pulse_receiver: RTL

Receive-side counterpart to the laser timer. Watches the asynchronous laser sensor line, measures each high pulse in clock cycles, and classifies it. A pulse within [MIN_LEN, MAX_LEN] produces a one-cycle `Hit` and advances a saturating hit counter. Any other length produces a one-cycle `Err`, and a line held high too long raises `Stuck`. Sits between the photodetector input and the scoring/telemetry logic.

---
 rtl/laser_pulse_receiver_pkg.sv | 20 ++
 rtl/laser_pulse_receiver_sync2.sv | 36 +++
 rtl/laser_pulse_receiver.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/laser_pulse_receiver_pkg.sv
// -----------------------------------------------------------------------------
// laser_pulse_receiver_pkg
// Shared definitions for the laser pulse receiver.
//   state_t         : receiver FSM state encoding (2 bits)
//   LASER_PULSE_LEN : nominal laser on-time in cycles. The transmit-side laser
//                     timer uses the same constant, so both ends agree on what
//                     a valid pulse looks like.
// -----------------------------------------------------------------------------
package laser_pulse_receiver_pkg;

  typedef enum logic [1:0] {
    S_Arm   = 2'd0,
    S_Idle  = 2'd1,
    S_High  = 2'd2,
    S_Stuck = 2'd3
  } state_t;

  localparam int unsigned LASER_PULSE_LEN = 3;

endpackage

// File: rtl/laser_pulse_receiver_sync2.sv
// -----------------------------------------------------------------------------
// laser_sync2
// Two-flop synchronizer for a single asynchronous input.
// Parameters:
//   RST_VAL : value both flops take during reset
// Ports:
//   i_clk : destination clock
//   i_rst : asynchronous active-high reset
//   i_d   : asynchronous input
//   o_q   : synchronized output (two cycles of latency)
// -----------------------------------------------------------------------------
module laser_sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/laser_pulse_receiver.sv
// -----------------------------------------------------------------------------
// laser_pulse_receiver
// Measures each high pulse on the asynchronous laser sensor line and
// classifies it. Lengths in [MIN_LEN, MAX_LEN] give a one-cycle Hit and bump a
// saturating hit counter; other lengths give a one-cycle Err. A line held high
// for STUCK_LEN cycles gives one Err and raises Stuck until the line drops.
// Ports:
//   Clk      : the only clock
//   Rst      : asynchronous active-high reset
//   L        : laser sensor line, asynchronous to Clk
//   Clr      : synchronous clear of HitCount (wins over a coincident hit)
//   Hit      : one-cycle pulse for a valid-length pulse
//   Err      : one-cycle pulse for a bad-length pulse or stuck entry
//   Stuck    : high while the line is considered stuck
//   HitCount : saturating count of valid pulses
//   LastLen  : length of the most recent completed or stuck pulse
//
// state   | meaning
// --------+-----------------------------------------------------------------
// S_Arm   | after reset; wait for the line to be low so a pulse already in
//         | progress is not measured
// S_Idle  | line low, waiting for the next pulse
// S_High  | line high, counting its length
// S_Stuck | line held high for STUCK_LEN cycles; wait for it to drop
// -----------------------------------------------------------------------------
module laser_pulse_receiver
  import laser_pulse_receiver_pkg::*;
#(
  parameter int unsigned MIN_LEN   = LASER_PULSE_LEN,
  parameter int unsigned MAX_LEN   = LASER_PULSE_LEN,
  parameter int unsigned STUCK_LEN = 15,
  parameter int unsigned LEN_W     = 4,
  parameter int unsigned CNT_W     = 8
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             L,
  input  logic             Clr,
  output logic             Hit,
  output logic             Err,
  output logic             Stuck,
  output logic [CNT_W-1:0] HitCount,
  output logic [LEN_W-1:0] LastLen
);

  localparam logic [LEN_W-1:0] MIN_L   = LEN_W'(MIN_LEN);
  localparam logic [LEN_W-1:0] MAX_L   = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] STUCK_L = LEN_W'(STUCK_LEN);
  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Registered state and outputs
  state_t           r_state;
  logic [LEN_W-1:0] r_len;
  logic             r_hit;
  logic             r_err;
  logic             r_stuck;
  logic [CNT_W-1:0] r_hit_count;
  logic [LEN_W-1:0] r_last_len;

  // Next-state values
  state_t           w_state_nxt;
  logic [LEN_W-1:0] w_len_nxt;
  logic             w_hit_nxt;
  logic             w_err_nxt;
  logic             w_stuck_nxt;
  logic [CNT_W-1:0] w_count_nxt;
  logic [LEN_W-1:0] w_last_len_nxt;

  logic             w_ls;
  logic [LEN_W-1:0] w_len_inc;
  logic             w_in_window;
  logic             w_count_inc;

  // Reset value 1 makes the line look high right after reset, so S_Arm always
  // waits for a genuine low before measuring anything.
  laser_sync2 #(
    .RST_VAL(1'b1)
  ) u_sync (
    .i_clk(Clk),
    .i_rst(Rst),
    .i_d  (L),
    .o_q  (w_ls)
  );

  // Len never exceeds STUCK_LEN-1 while counting, so the increment cannot wrap.
  assign w_len_inc   = r_len + LEN_ONE;
  assign w_in_window = (r_len >= MIN_L) && (r_len <= MAX_L);

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_state     <= S_Arm;
      r_len       <= '0;
      r_hit       <= 1'b0;
      r_err       <= 1'b0;
      r_stuck     <= 1'b0;
      r_hit_count <= '0;
      r_last_len  <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_len       <= w_len_nxt;
      r_hit       <= w_hit_nxt;
      r_err       <= w_err_nxt;
      r_stuck     <= w_stuck_nxt;
      r_hit_count <= w_count_nxt;
      r_last_len  <= w_last_len_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_len_nxt      = r_len;
    w_hit_nxt      = 1'b0;
    w_err_nxt      = 1'b0;
    w_stuck_nxt    = r_stuck;
    w_last_len_nxt = r_last_len;
    w_count_inc    = 1'b0;
    w_count_nxt    = r_hit_count;

    case (r_state)
      S_Arm: begin
        if (!w_ls) begin
          w_state_nxt = S_Idle;
        end
      end

      S_Idle: begin
        if (w_ls) begin
          w_state_nxt = S_High;
          w_len_nxt   = LEN_ONE;
        end
      end

      S_High: begin
        if (w_ls) begin
          w_len_nxt = w_len_inc;
          if (w_len_inc == STUCK_L) begin
            w_state_nxt    = S_Stuck;
            w_err_nxt      = 1'b1;
            w_stuck_nxt    = 1'b1;
            w_last_len_nxt = STUCK_L;
          end
        end else begin
          // A single low cycle is enough: S_Idle can re-enter S_High on the
          // very next edge, so back-to-back pulses are both measured.
          w_state_nxt    = S_Idle;
          w_last_len_nxt = r_len;
          if (w_in_window) begin
            w_hit_nxt   = 1'b1;
            w_count_inc = 1'b1;
          end else begin
            w_err_nxt = 1'b1;
          end
        end
      end

      S_Stuck: begin
        if (!w_ls) begin
          w_state_nxt = S_Idle;
          w_stuck_nxt = 1'b0;
        end
      end

      default: begin
        w_state_nxt = S_Arm;
      end
    endcase

    // Clear takes priority over a coincident hit; Hit itself still pulses.
    if (Clr) begin
      w_count_nxt = '0;
    end else if (w_count_inc && (r_hit_count != CNT_MAX)) begin
      w_count_nxt = r_hit_count + CNT_ONE;
    end
  end

  assign Hit      = r_hit;
  assign Err      = r_err;
  assign Stuck    = r_stuck;
  assign HitCount = r_hit_count;
  assign LastLen  = r_last_len;

endmodule
